// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the multi-channel first-order IIR filter.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } iir_state_e;

    localparam logic MODE_HPF = 1'b0;
    localparam logic MODE_LPF = 1'b1;

    // Half an LSB of the coefficient scale, added before the shift for round half-up.
    function automatic logic [63:0] round_const(input int unsigned coef_w);
        return (coef_w == 0) ? 64'd0 : (64'd1 << (coef_w - 1));
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/iir1_filter_mc_if.sv
// Frame-level handshake between the audio path and the IIR filter.
interface iir1_filter_mc_if #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned COEF_W   = 16
);
    logic                         in_valid;
    logic [NUM_CH*SAMPLE_W-1:0]   in_data;
    logic [COEF_W-1:0]            coef;
    logic                         mode;
    logic                         clear;
    logic                         busy;
    logic                         out_valid;
    logic [NUM_CH*SAMPLE_W-1:0]   out_data;
    logic                         overrun;

    modport master (
        output in_valid, in_data, coef, mode, clear,
        input  busy, out_valid, out_data, overrun
    );

    modport slave (
        input  in_valid, in_data, coef, mode, clear,
        output busy, out_valid, out_data, overrun
    );
endinterface

// File: rtl/iir1_mac.sv
// Single-channel combinational IIR datapath: y from (x, x1, y1, coef, mode).
// IIR1_SATURATE_EN selects saturation; otherwise the result wraps to SAMPLE_W bits.
module iir1_mac
    import iir_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned COEF_W   = 16
) (
    input  logic signed [SAMPLE_W-1:0] x,
    input  logic signed [SAMPLE_W-1:0] x1,
    input  logic signed [SAMPLE_W-1:0] y1,
    input  logic        [COEF_W-1:0]   coef,
    input  logic                       mode,
    output logic signed [SAMPLE_W-1:0] y
);
    localparam int unsigned W  = SAMPLE_W + 2;
    localparam int unsigned RW = W + 1;
    localparam int unsigned PW = W + COEF_W + 1;

    logic signed [W-1:0]  xe, x1e, y1e, diff, scaled;
    logic signed [PW-1:0] diff_x, coef_x, prod, rnd, shifted;
    logic signed [RW-1:0] y_full;

    always_comb begin
        xe      = W'(x);
        x1e     = W'(x1);
        y1e     = W'(y1);
        diff    = (mode == MODE_LPF) ? (xe - y1e) : (y1e + xe - x1e);
        diff_x  = PW'(diff);
        coef_x  = $signed(PW'(coef));
        prod    = diff_x * coef_x;
        rnd     = prod + $signed(PW'(round_const(COEF_W)));
        shifted = rnd >>> COEF_W;
        scaled  = W'(shifted);
        y_full  = (mode == MODE_LPF) ? (RW'(scaled) + RW'(y1e)) : RW'(scaled);
`ifdef IIR1_SATURATE_EN
        y = SAMPLE_W'(saturate(64'(y_full), SAMPLE_W));
`else
        y = y_full[SAMPLE_W-1:0];
`endif
    end

endmodule

// File: rtl/iir1_filter_mc.sv
// First-order HPF/LPF over NUM_CH packed channels sharing one multiplier, one channel per cycle.
// Build option IIR1_SATURATE_EN: saturate results instead of wrapping.
module iir1_filter_mc
    import iir_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned COEF_W   = 16
) (
    input logic             AUDIO_CLK,
    input logic             rst,
    iir1_filter_mc_if.slave bus
);
    localparam int unsigned DW     = NUM_CH * SAMPLE_W;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SLOT_W = $clog2(DW);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    iir_state_e state_q, state_d;

    logic [CH_W-1:0]   ch_q;
    logic [DW-1:0]     x_frame_q, shadow_q, shadow_d, out_data_q;
    logic [COEF_W-1:0] coef_q;
    logic              mode_q;
    logic signed [SAMPLE_W-1:0] x1_q [NUM_CH];
    logic signed [SAMPLE_W-1:0] y1_q [NUM_CH];
    logic busy_q, out_valid_q, overrun_q;
    logic accept, last_ch;
    logic [SLOT_W-1:0] slot;
    logic signed [SAMPLE_W-1:0] x_sel, y_calc;

    assign accept  = (state_q == IDLE) && bus.in_valid && !bus.clear;
    assign last_ch = (ch_q == LAST_CH);

    // Channel 0 sits in the MSBs, so the slot offset counts down with the channel index.
    always_comb begin
        slot     = SLOT_W'((NUM_CH - 1 - 32'(ch_q)) * SAMPLE_W);
        x_sel    = x_frame_q[slot +: SAMPLE_W];
        shadow_d = shadow_q;
        shadow_d[slot +: SAMPLE_W] = y_calc;
    end

    iir1_mac #(
        .SAMPLE_W(SAMPLE_W),
        .COEF_W  (COEF_W)
    ) u_mac (
        .x   (x_sel),
        .x1  (x1_q[ch_q]),
        .y1  (y1_q[ch_q]),
        .coef(coef_q),
        .mode(mode_q),
        .y   (y_calc)
    );

    always_ff @(posedge AUDIO_CLK or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (bus.clear) state_d = IDLE;
                     else if (last_ch) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The shadow is published on the last CALC edge so out_valid is high during DONE,
    // keeping the accept-to-valid latency at NUM_CH+1.
    always_ff @(posedge AUDIO_CLK or negedge rst) begin
        if (!rst) begin
            ch_q        <= '0;
            x_frame_q   <= '0;
            coef_q      <= '0;
            mode_q      <= MODE_HPF;
            shadow_q    <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                x1_q[i] <= '0;
                y1_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            overrun_q   <= bus.in_valid && (state_q != IDLE);
            if (bus.clear) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    x1_q[i] <= '0;
                    y1_q[i] <= '0;
                end
                ch_q   <= '0;
                busy_q <= 1'b0;
            end else if (accept) begin
                x_frame_q <= bus.in_data;
                coef_q    <= bus.coef;
                mode_q    <= bus.mode;
                ch_q      <= '0;
                busy_q    <= 1'b1;
            end else if (state_q == CALC) begin
                shadow_q   <= shadow_d;
                x1_q[ch_q] <= x_sel;
                y1_q[ch_q] <= y_calc;
                ch_q       <= ch_q + 1'b1;
                if (last_ch) begin
                    out_data_q  <= shadow_d;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_iir1_filter_mc.sv
// Bench for iir1_filter_mc: directed cases plus random frames against an arithmetic reference.
module tb_iir1_filter_mc;
    localparam int unsigned SW  = 16;
    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned DW  = NCH * SW;
    localparam longint SMAX = (longint'(1) <<< (SW - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;
    localparam longint ONE  = longint'(1) <<< CW;

    logic AUDIO_CLK = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    longint stim   [NCH];
    longint m_x1   [NCH];
    longint m_y1   [NCH];
    longint m_last [NCH];

    iir1_filter_mc_if #(.SAMPLE_W(SW), .NUM_CH(NCH), .COEF_W(CW)) bus ();

    iir1_filter_mc #(.SAMPLE_W(SW), .NUM_CH(NCH), .COEF_W(CW)) dut (
        .AUDIO_CLK(AUDIO_CLK),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 AUDIO_CLK = ~AUDIO_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge AUDIO_CLK);
        #1;
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint fit(input longint v);
        longint span;
        longint r;
        span = 2 * (SMAX + 1);
`ifdef IIR1_SATURATE_EN
        r = (v > SMAX) ? SMAX : ((v < SMIN) ? SMIN : v);
`else
        r = ((v % span) + span) % span;
        if (r > SMAX) r = r - span;
`endif
        return r;
    endfunction

    function automatic longint lane(input logic [DW-1:0] d, input int unsigned ch);
        logic [SW-1:0] s;
        s = SW'(d >> ((NCH - 1 - ch) * SW));
        return longint'($signed(s));
    endfunction

    function automatic logic [DW-1:0] pack_stim();
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        d = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            s = SW'(stim[ch]);
            d = (d << SW) | DW'(s);
        end
        return d;
    endfunction

    task automatic model_clear();
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            m_x1[ch] = 0;
            m_y1[ch] = 0;
        end
    endtask

    // y = a*(y1 + x - x1) for high-pass, y = y1 + a*(x - y1) for low-pass, a = c / 2^CW.
    task automatic model_frame(input longint c, input logic m);
        longint x, y;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            x = stim[ch];
            if (m == 1'b0) y = fit(floor_div((m_y1[ch] + x - m_x1[ch]) * c + ONE / 2, ONE));
            else           y = fit(m_y1[ch] + floor_div((x - m_y1[ch]) * c + ONE / 2, ONE));
            m_x1[ch]   = x;
            m_y1[ch]   = y;
            m_last[ch] = y;
        end
    endtask

    task automatic check_out(input string tag);
        for (int unsigned ch = 0; ch < NCH; ch++)
            check($sformatf("%s_ch%0d", tag, ch), lane(bus.out_data, ch), m_last[ch]);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
    endtask

    task automatic run_frame(input logic [CW-1:0] c, input logic m);
        int unsigned n;
        bus.in_data  = pack_stim();
        bus.coef     = c;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("busy_calc", bus.busy, 1);
        model_frame(longint'(c), m);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check("latency", n, NCH + 1);
        check("busy_done", bus.busy, 0);
        check_out("frame");
        tick();
        check("valid_pulse", bus.out_valid, 0);
    endtask

    task automatic count_valid(input int unsigned cycles, output int unsigned cnt);
        cnt = 0;
        repeat (cycles) begin
            tick();
            if (bus.out_valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        int unsigned cnt;
        logic [DW-1:0] first_data;
        logic [CW-1:0] c;
        logic m;

        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.coef     = '0;
        bus.mode     = 1'b0;
        bus.clear    = 1'b0;
        model_clear();
        for (int unsigned ch = 0; ch < NCH; ch++) m_last[ch] = 0;
        repeat (2) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_data", bus.out_data, 0);
        #2 rst = 1'b1;
        tick();

        // High-pass step response
        stim[0] = 1000; stim[1] = 1000;
        run_frame(16'h8000, 1'b0);
        check("hpf1_ch0", lane(bus.out_data, 0), 500);
        check("hpf1_ch1", lane(bus.out_data, 1), 500);
        run_frame(16'h8000, 1'b0);
        check("hpf2_ch0", lane(bus.out_data, 0), 250);
        check("hpf2_ch1", lane(bus.out_data, 1), 250);

        // Low-pass step response, then coef=0 holds y1
        do_clear();
        stim[0] = 1000; stim[1] = -1000;
        run_frame(16'h8000, 1'b1);
        check("lpf1_ch0", lane(bus.out_data, 0), 500);
        check("lpf1_ch1", lane(bus.out_data, 1), -500);
        run_frame(16'h8000, 1'b1);
        check("lpf2_ch0", lane(bus.out_data, 0), 750);
        check("lpf2_ch1", lane(bus.out_data, 1), -750);
        stim[0] = 30000; stim[1] = -12345;
        run_frame(16'h0000, 1'b1);
        check("lpf_c0_ch0", lane(bus.out_data, 0), 750);
        check("lpf_c0_ch1", lane(bus.out_data, 1), -750);

        // High-pass with coef=0 yields zero
        do_clear();
        stim[0] = 1234; stim[1] = -77;
        run_frame(16'h0000, 1'b0);
        check("hpf_c0_ch0", lane(bus.out_data, 0), 0);
        check("hpf_c0_ch1", lane(bus.out_data, 1), 0);

        // Full-scale swing exercises saturation / wrap
        do_clear();
        stim[0] = -32768; stim[1] = 0;
        run_frame(16'hFFFF, 1'b0);
        check("sat1_ch0", lane(bus.out_data, 0), -32767);
        stim[0] = 32767; stim[1] = 0;
        run_frame(16'hFFFF, 1'b0);
`ifdef IIR1_SATURATE_EN
        check("sat2_ch0", lane(bus.out_data, 0), 32767);
`else
        check("wrap2_ch0", lane(bus.out_data, 0), -32768);
`endif

        // clear and in_valid together in IDLE: clear wins
        stim[0] = 4000; stim[1] = 4000;
        bus.in_data = pack_stim(); bus.coef = 16'h8000; bus.mode = 1'b0;
        bus.in_valid = 1'b1; bus.clear = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.clear = 1'b0;
        model_clear();
        check("clr_iv_overrun", bus.overrun, 0);
        check("clr_iv_busy", bus.busy, 0);
        count_valid(4, cnt);
        check("clr_iv_novalid", cnt, 0);
        check_out("clr_iv_hold");

        // Back-to-back in_valid: second frame dropped with overrun
        stim[0] = 1000; stim[1] = -2000;
        first_data = pack_stim();
        bus.in_data = first_data; bus.coef = 16'h8000; bus.mode = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        model_frame(longint'(16'h8000), 1'b0);
        bus.in_data = ~first_data;
        tick();
        bus.in_valid = 1'b0;
        check("ovr_pulse", bus.overrun, 1);
        check("ovr_busy", bus.busy, 1);
        tick();
        check("ovr_valid", bus.out_valid, 1);
        check("ovr_pulse_end", bus.overrun, 0);
        check_out("ovr_data");
        count_valid(4, cnt);
        check("ovr_single_valid", cnt, 0);
        stim[0] = 1000; stim[1] = -2000;
        run_frame(16'h8000, 1'b0);

        // clear during CALC aborts the frame
        stim[0] = 9000; stim[1] = 9000;
        bus.in_data = pack_stim(); bus.coef = 16'h8000; bus.mode = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.out_valid, 0);
        count_valid(5, cnt);
        check("abort_novalid", cnt, 0);
        stim[0] = 1000; stim[1] = 1000;
        run_frame(16'h8000, 1'b0);
        check("abort_next_ch0", lane(bus.out_data, 0), 500);
        check("abort_next_ch1", lane(bus.out_data, 1), 500);

        // Asynchronous reset mid-CALC
        stim[0] = 3000; stim[1] = 3000;
        bus.in_data = pack_stim(); bus.coef = 16'h8000; bus.mode = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_data", bus.out_data, 0);
        model_clear();
        for (int unsigned ch = 0; ch < NCH; ch++) m_last[ch] = 0;
        tick();
        check("arst_held_valid", bus.out_valid, 0);
        #3 rst = 1'b1;
        tick();
        stim[0] = 1000; stim[1] = 1000;
        run_frame(16'h8000, 1'b0);
        check("arst_next_ch0", lane(bus.out_data, 0), 500);
        check("arst_next_ch1", lane(bus.out_data, 1), 500);

        // Random frames; clear on each mode change, idle gaps verify out_data holds
        for (int b = 0; b < 4; b++) begin
            m = (b % 2 == 1);
            do_clear();
            for (int f = 0; f < 10; f++) begin
                for (int unsigned ch = 0; ch < NCH; ch++) begin
                    stim[ch] = longint'($signed(16'($urandom())));
                    if ($urandom_range(0, 4) == 0)
                        stim[ch] = ($urandom_range(0, 1) == 1) ? SMAX : SMIN;
                end
                c = 16'($urandom());
                if ($urandom_range(0, 7) == 0) c = 16'hFFFF;
                run_frame(c, m);
                repeat ($urandom_range(0, 2)) tick();
                check_out("rand_hold");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
